// File: rtl/prime_pkg.sv
// Shared definitions for the prime scan stage and the combinational checker it drives.
package prime_pkg;

    localparam int PRIME_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/checkP.sv
// Combinational primality checker by trial division; sits beside prime_scan_ctrl in the parent.
module checkP
    import prime_pkg::*;
#(
    parameter int W = PRIME_W
) (
    input  logic [W-1:0] n,
    output logic         isP
);

    always_comb begin
        isP = (int'(n) >= 2);
        for (int d = 2; d < (1 << W); d++) begin
            if ((d < int'(n)) && ((int'(n) % d) == 0)) begin
                isP = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prime_scan_ctrl.sv
// Steps an external prime checker across [lo, hi], one value per cycle, and accumulates
// the prime count and the last (largest) prime seen.
module prime_scan_ctrl
    import prime_pkg::*;
#(
    parameter int W = PRIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] n,
    input  logic         isP,
    output logic         busy,
    output logic         done,
    output logic [W:0]   count,
    output logic [W-1:0] last_prime,
    output logic         found
);

    localparam logic [W-1:0] ONE_N = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_C = {{W{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W:0]   count_q, count_d;
    logic [W-1:0] last_prime_q, last_prime_d;
    logic         found_q, found_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        hi_d         = hi_q;
        count_d      = count_q;
        last_prime_d = last_prime_q;
        found_d      = found_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d      = '0;
                    found_d      = 1'b0;
                    last_prime_d = '0;
                    if (lo <= hi) begin
                        state_d = SCAN;
                        hi_d    = hi;
                        n_d     = lo;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (isP) begin
                    count_d      = count_q + ONE_C;
                    last_prime_d = n_q;
                    found_d      = 1'b1;
                end
                // Compare before incrementing so hi = all-ones terminates without wrapping n.
                if (n_q == hi_q) begin
                    state_d = DONE;
                end else begin
                    n_d = n_q + ONE_N;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            hi_q         <= '0;
            count_q      <= '0;
            last_prime_q <= '0;
            found_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            hi_q         <= hi_d;
            count_q      <= count_d;
            last_prime_q <= last_prime_d;
            found_q      <= found_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign n          = n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;
    assign last_prime = last_prime_q;
    assign found      = found_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed bench for prime_scan_ctrl with the real checkP wired in, W = 3 (primes 2,3,5,7).
module tb_prime_scan_ctrl;
    import prime_pkg::*;

    localparam int W = PRIME_W;
    localparam int MAX_CYC = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] n;
    logic         isP;
    logic         busy;
    logic         done;
    logic [W:0]   count;
    logic [W-1:0] last_prime;
    logic         found;

    int n_checks = 0;
    int n_errors = 0;

    prime_scan_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lo         (lo),
        .hi         (hi),
        .n          (n),
        .isP        (isP),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .last_prime (last_prime),
        .found      (found)
    );

    checkP #(.W(W)) u_chk (
        .n   (n),
        .isP (isP)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge; returns in cycle 1 after the accepting edge.
    task automatic do_start(input logic [W-1:0] l, input logic [W-1:0] h);
        lo    = l;
        hi    = h;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle (or after the bound) with its cycle number.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < MAX_CYC) begin
            step();
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic check_results(input string tag, input logic [W:0] e_cnt,
                                 input logic [W-1:0] e_last, input logic e_found);
        n_checks++;
        if (count !== e_cnt) begin
            n_errors++;
            $display("FAIL %s count: got %0d, required %0d", tag, count, e_cnt);
        end
        n_checks++;
        if (found !== e_found) begin
            n_errors++;
            $display("FAIL %s found: got %b, required %b", tag, found, e_found);
        end
        n_checks++;
        if (last_prime !== e_last) begin
            n_errors++;
            $display("FAIL %s last_prime: got %0d, required %0d", tag, last_prime, e_last);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        lo    = '0;
        hi    = '0;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({n, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset n/busy/done: got %0d/%b/%b, required 0/0/0", n, busy, done);
        end
        check_results("reset", 4'd0, 3'd0, 1'b0);
    endtask

    task automatic test_full_range();
        do_start(3'd0, 3'd7);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (n !== 3'(k - 1) || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL full_scan cycle %0d: n=%0d busy=%b done=%b, required n=%0d busy=1 done=0",
                         k, n, busy, done, k - 1);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || n !== 3'd7) begin
            n_errors++;
            $display("FAIL full_done cycle 9: done=%b busy=%b n=%0d, required 1/1/7", done, busy, n);
        end
        check_results("full", 4'd4, 3'd7, 1'b1);
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL full_idle cycle 10: done=%b busy=%b, required 0/0", done, busy);
        end
        check_results("full_hold", 4'd4, 3'd7, 1'b1);
    endtask

    task automatic test_sub_range();
        int cyc;
        do_start(3'd4, 3'd6);
        wait_done(cyc);
        n_checks++;
        if (cyc != 4) begin
            n_errors++;
            $display("FAIL sub_latency: done in cycle %0d, required 4", cyc);
        end
        check_results("sub", 4'd1, 3'd5, 1'b1);
        step();
    endtask

    task automatic test_single_and_empty();
        int cyc;
        do_start(3'd1, 3'd1);
        wait_done(cyc);
        n_checks++;
        if (cyc != 2) begin
            n_errors++;
            $display("FAIL single_latency: done in cycle %0d, required 2", cyc);
        end
        check_results("single", 4'd0, 3'd0, 1'b0);
        step();
        do_start(3'd6, 3'd2);
        wait_done(cyc);
        n_checks++;
        if (cyc != 1 || n !== 3'd1) begin
            n_errors++;
            $display("FAIL empty_latency: done in cycle %0d n=%0d, required cycle 1 n=1", cyc, n);
        end
        check_results("empty", 4'd0, 3'd0, 1'b0);
        step();
    endtask

    task automatic test_start_held();
        int cyc;
        lo    = 3'd0;
        hi    = 3'd7;
        start = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                lo = 3'd3;
                hi = 3'd4;
            end
            n_checks++;
            if (n !== 3'(k - 1) || done !== 1'b0) begin
                n_errors++;
                $display("FAIL held_scan cycle %0d: n=%0d done=%b, required n=%0d done=0", k, n, done, k - 1);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL held_done cycle 9: done=%b, required 1", done);
        end
        check_results("held", 4'd4, 3'd7, 1'b1);
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL held_idle: busy=%b done=%b, required 0/0", busy, done);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || n !== 3'd3) begin
            n_errors++;
            $display("FAIL held_restart: busy=%b n=%0d, required 1/3", busy, n);
        end
        wait_done(cyc);
        check_results("held_second", 4'd1, 3'd3, 1'b1);
        step();
    endtask

    task automatic test_mid_reset();
        int cyc;
        do_start(3'd0, 3'd7);
        cyc = 1;
        while (n !== 3'd5 && cyc < MAX_CYC) begin
            step();
            cyc++;
        end
        n_checks++;
        if (n !== 3'd5 || count !== 4'd2) begin
            n_errors++;
            $display("FAIL midrst_pre: n=%0d count=%0d, required n=5 count=2", n, count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (n !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_post: n=%0d busy=%b done=%b, required 0/0/0", n, busy, done);
        end
        check_results("midrst", 4'd0, 3'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_quiet %0d: done=%b busy=%b, required 0/0", k, done, busy);
            end
            step();
        end
        do_start(3'd2, 3'd3);
        wait_done(cyc);
        check_results("after_rst", 4'd2, 3'd3, 1'b1);
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_start(3'd0, 3'd3);
        wait_done(cyc);
        check_results("b2b_first", 4'd2, 3'd3, 1'b1);
        lo    = 3'd5;
        hi    = 3'd7;
        start = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0/0", busy, done);
        end
        check_results("b2b_hold", 4'd2, 3'd3, 1'b1);
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || n !== 3'd5 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL b2b_accept: busy=%b n=%0d count=%0d, required 1/5/0", busy, n, count);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 4) begin
            n_errors++;
            $display("FAIL b2b_latency: done in cycle %0d, required 4", cyc);
        end
        check_results("b2b_second", 4'd2, 3'd7, 1'b1);
        step();
        check_results("b2b_stable", 4'd2, 3'd7, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_sub_range();
        test_single_and_empty();
        test_start_held();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prime_scan_ctrl.md
Name: prime_scan_ctrl

Overview:
- Sequencing stage wrapped around the existing combinational prime checker (checkP).
- Drives the checker's n input across a requested range [lo, hi] at one value per cycle, and samples the checker's isP result each cycle.
- Reports the number of primes found and the last prime seen.
- The parent instantiates checkP beside this block and wires n -> checkP.n and checkP.isP -> isP. No combinational path runs from isP back to n.

Parameters:
- W, 3, width of scanned values. Must match the checker's n width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE.
- lo  input  W  first value of range; sampled with an accepted start.
- hi  input  W  last value of range; sampled with an accepted start.
- n  output  W  value under test, driven to the checker; registered.
- isP  input  1  checker result for the current n; combinational from n.
- busy  output  1  high while in SCAN or DONE.
- done  output  1  one-cycle pulse when the scan completes.
- count  output  W+1  number of primes found in the last scan.
- last_prime  output  W  largest prime found in the last scan; valid only when found=1.
- found  output  1  at least one prime found in the last scan.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; n=0, busy=0, done=0, count=0, last_prime=0, found=0. Reset overrides all other inputs, including mid-scan; a partial scan is discarded.
- States:
  - IDLE: busy=0, done=0. Results from the previous scan hold.
  - IDLE -> SCAN: start=1 and lo<=hi (unsigned). Latch hi internally; n<=lo; count<=0; found<=0; last_prime<=0.
  - IDLE -> DONE: start=1 and lo>hi. Clear count, found and last_prime; n unchanged.
  - SCAN: each cycle, if isP=1 then count<=count+1, last_prime<=n, found<=1.
    - If n==latched hi, go to DONE; n holds.
    - Otherwise n<=n+1.
    - The equality test happens before the increment, so hi=2^W-1 never wraps n.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE. Results stay stable from DONE onward until the next accepted start.
- start is ignored in SCAN and DONE; it is not queued. lo and hi changes after acceptance have no effect.
- Latency:
  - SCAN lasts hi-lo+1 cycles.
  - done is high in cycle hi-lo+2 after the accepting edge (edge = cycle 0).
  - For lo>hi, done is high in cycle 1.
- Width: count is W+1 bits so that 2^W primes cannot overflow (the bound is never reached for real prime sets, but the width is fixed).
- Back-to-back: start asserted in the IDLE cycle right after DONE is accepted. Minimum spacing between scans is SCAN+2 cycles.

Decomposition:
- Shared package prime_pkg:
  - state enum {IDLE, SCAN, DONE}, 2-bit encoding.
  - default-width constant PRIME_W=3, used by both this block and the checker.
- No sub-module. The checker stays external so that it can be tested and reused standalone. All logic is one FSM plus counter/accumulator registers.

Test Plan (W=3, real checkP wired in):
1. lo=0, hi=7, start for 1 cycle -> n steps 0..7 over 8 cycles; done pulses at cycle 9; count=4, last_prime=7, found=1; busy high from cycle 1 to 9.
2. lo=4, hi=6 -> 3 SCAN cycles; done at cycle 4; count=1, last_prime=5, found=1.
3. lo=1, hi=1 -> 1 SCAN cycle; done at cycle 2; count=0, found=0, last_prime=0. Then lo=6, hi=2 -> done at cycle 1; count=0, found=0.
4. lo=0, hi=7 with start held high continuously -> every start during SCAN/DONE is ignored (lo/hi changes have no effect); first scan gives count=4; a new scan starts in the IDLE cycle right after done.
5. rst=1 asserted when n=5 mid-scan of 0..7 -> next cycle: IDLE, n=0, count=0, found=0, busy=0, no done pulse. A following scan of 2..3 gives count=2, last_prime=3.
6. Back-to-back scans 0..3 then 5..7 with start in the IDLE cycle after the first done -> results 2/3/found=1 become 2/7/found=1; count stays stable from each done until the next accepted start.
